// File: rtl/perf_mon_pkg.sv
// Shared types and helpers for the CPU performance monitor.
// Imported by the monitor top and its event counters.
package perf_mon_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        HALTED  = 2'd2,
        TIMEOUT = 2'd3
    } state_t;

    // Cycle counter sits directly after the last event channel.
    localparam int CYC_SEL_OFFSET = 0;

    function automatic int idx_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/perf_event_counter.sv
// Single event counter with saturate-or-wrap and sticky overflow.
// Shared by every event channel and the cycle counter.
module perf_event_counter
    import perf_mon_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter int SAT_MODE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             ovf
);

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (inc) begin
            if (&cnt) begin
                ovf <= 1'b1;
                cnt <= (SAT_MODE != 0) ? cnt : '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cpu_perf_monitor.sv
// Performance monitor: event/cycle counters, halt/watchdog freeze,
// and a single-outstanding read port.
module cpu_perf_monitor
    import perf_mon_pkg::*;
#(
    parameter int          NUM_EVT  = 8,
    parameter int          CNT_W    = 32,
    parameter int          SAT_MODE = 1,
    parameter int unsigned MAX_CYC  = 100000,
    parameter int          IDX_W    = idx_w(NUM_EVT)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [NUM_EVT-1:0] evt,
    input  logic               hlt,
    input  logic               clr,
    input  logic               rd_req,
    input  logic [IDX_W-1:0]   rd_idx,
    output logic               rd_ack,
    output logic [CNT_W-1:0]   rd_data,
    output logic               rd_err,
    output logic [NUM_EVT-1:0] ovf,
    output logic [1:0]         state,
    output logic               done
);

    localparam int CYC_IDX = NUM_EVT + CYC_SEL_OFFSET;

    state_t           st;
    state_t           stNext;
    logic [CNT_W-1:0] cnts [NUM_EVT+1];
    logic [NUM_EVT:0] inc;
    logic             running;
    logic [CNT_W-1:0] cycPost;
    logic             wdHit;
    logic             rdPend;
    logic [IDX_W-1:0] rdIdxQ;
    logic [CNT_W-1:0] selData;
    logic             selErr;
    logic             unusedCycOvf;

    assign running = (st == RUN) && !clr;
    assign inc     = {running, evt & {NUM_EVT{running}}};

    for (genvar i = 0; i <= NUM_EVT; i++) begin : gCnt
        if (i < CYC_IDX) begin : gEvt
            perf_event_counter #(
                .CNT_W    (CNT_W),
                .SAT_MODE (SAT_MODE)
            ) uCnt (
                .clk   (clk),
                .rst_n (rst_n),
                .clr   (clr),
                .inc   (inc[i]),
                .cnt   (cnts[i]),
                .ovf   (ovf[i])
            );
        end else begin : gCyc
            perf_event_counter #(
                .CNT_W    (CNT_W),
                .SAT_MODE (SAT_MODE)
            ) uCnt (
                .clk   (clk),
                .rst_n (rst_n),
                .clr   (clr),
                .inc   (inc[i]),
                .cnt   (cnts[i]),
                .ovf   (unusedCycOvf)
            );
        end
    end

    // Watchdog compares against the value the cycle counter takes this edge.
    assign cycPost = ((SAT_MODE != 0) && (&cnts[CYC_IDX]))
                   ? cnts[CYC_IDX]
                   : cnts[CYC_IDX] + 1'b1;
    assign wdHit = (MAX_CYC != 0)
                && (64'(cycPost) == 64'(MAX_CYC));

    always_comb begin
        stNext = st;
        unique case (st)
            IDLE:    if (en) stNext = RUN;
            RUN: begin
                if (hlt)        stNext = HALTED;
                else if (wdHit) stNext = TIMEOUT;
            end
            HALTED:  stNext = HALTED;
            TIMEOUT: stNext = TIMEOUT;
            default: stNext = IDLE;
        endcase
        if (clr) stNext = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) st <= IDLE;
        else        st <= stNext;
    end

    assign state = st;
    assign done  = (st == HALTED) || (st == TIMEOUT);

    always_comb begin
        selData = '0;
        selErr  = 1'b0;
        if (int'(rdIdxQ) > NUM_EVT) selErr  = 1'b1;
        else                        selData = cnts[rdIdxQ];
    end

    // Index latched at accept; data sampled one edge later so it
    // reflects the counters after the accept edge's update.
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            rdPend  <= 1'b0;
            rdIdxQ  <= '0;
            rd_ack  <= 1'b0;
            rd_data <= '0;
            rd_err  <= 1'b0;
        end else begin
            rd_ack <= rdPend;
            rdPend <= rd_req && !rdPend;
            if (rd_req && !rdPend) rdIdxQ <= rd_idx;
            if (rdPend) begin
                rd_data <= selData;
                rd_err  <= selErr;
            end
        end
    end

endmodule

// File: tb/tb_cpu_perf_monitor.sv
// Self-checking bench for cpu_perf_monitor: directed scenarios on four
// parameterisations plus a randomized run against an abstract model.
module tb_cpu_perf_monitor;

    localparam int NE = 8;
    localparam int NK = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, en, hlt, clr, rd_req;
    logic [NE-1:0] evt;
    logic [3:0]    rd_idx;

    logic aAck, aErr, aDone, tAck, tErr, tDone;
    logic sAck, sErr, sDone, wAck, wErr, wDone;
    logic [31:0] aData, tData;
    logic [7:0]  sData, wData;
    logic [7:0]  aOvf, tOvf, sOvf, wOvf;
    logic [1:0]  aSt, tSt, sSt, wSt;

    cpu_perf_monitor #(.NUM_EVT(NE), .CNT_W(32), .SAT_MODE(1), .MAX_CYC(100000)) dutA (
        .clk(clk), .rst_n(rst_n), .en(en), .evt(evt), .hlt(hlt), .clr(clr),
        .rd_req(rd_req), .rd_idx(rd_idx), .rd_ack(aAck), .rd_data(aData),
        .rd_err(aErr), .ovf(aOvf), .state(aSt), .done(aDone));

    cpu_perf_monitor #(.NUM_EVT(NE), .CNT_W(32), .SAT_MODE(0), .MAX_CYC(50)) dutT (
        .clk(clk), .rst_n(rst_n), .en(en), .evt(evt), .hlt(hlt), .clr(clr),
        .rd_req(rd_req), .rd_idx(rd_idx), .rd_ack(tAck), .rd_data(tData),
        .rd_err(tErr), .ovf(tOvf), .state(tSt), .done(tDone));

    cpu_perf_monitor #(.NUM_EVT(NE), .CNT_W(8), .SAT_MODE(1), .MAX_CYC(0)) dutS (
        .clk(clk), .rst_n(rst_n), .en(en), .evt(evt), .hlt(hlt), .clr(clr),
        .rd_req(rd_req), .rd_idx(rd_idx), .rd_ack(sAck), .rd_data(sData),
        .rd_err(sErr), .ovf(sOvf), .state(sSt), .done(sDone));

    cpu_perf_monitor #(.NUM_EVT(NE), .CNT_W(8), .SAT_MODE(0), .MAX_CYC(0)) dutW (
        .clk(clk), .rst_n(rst_n), .en(en), .evt(evt), .hlt(hlt), .clr(clr),
        .rd_req(rd_req), .rd_idx(rd_idx), .rd_ack(wAck), .rd_data(wData),
        .rd_err(wErr), .ovf(wOvf), .state(wSt), .done(wDone));

    logic        oAck  [NK];
    logic        oErr  [NK];
    logic        oDone [NK];
    logic [31:0] oData [NK];
    logic [7:0]  oOvf  [NK];
    logic [1:0]  oSt   [NK];

    assign oAck[0] = aAck;  assign oAck[1] = tAck;
    assign oAck[2] = sAck;  assign oAck[3] = wAck;
    assign oErr[0] = aErr;  assign oErr[1] = tErr;
    assign oErr[2] = sErr;  assign oErr[3] = wErr;
    assign oDone[0] = aDone; assign oDone[1] = tDone;
    assign oDone[2] = sDone; assign oDone[3] = wDone;
    assign oData[0] = aData; assign oData[1] = tData;
    assign oData[2] = {24'd0, sData}; assign oData[3] = {24'd0, wData};
    assign oOvf[0] = aOvf;  assign oOvf[1] = tOvf;
    assign oOvf[2] = sOvf;  assign oOvf[3] = wOvf;
    assign oSt[0] = aSt;    assign oSt[1] = tSt;
    assign oSt[2] = sSt;    assign oSt[3] = wSt;

    int     cw   [NK] = '{32, 32, 8, 8};
    int     sat  [NK] = '{1, 0, 1, 0};
    longint maxc [NK] = '{100000, 50, 0, 0};

    int nChk  = 0;
    int nFail = 0;

    // Abstract model: unbounded counts, width/saturation applied on view.
    longint mCnt  [NK][NE+1];
    int     mSt   [NK];
    bit     mPend [NK];
    int     mIdx  [NK];
    bit     eAck  [NK];
    longint eData [NK];
    bit     eErr  [NK];
    bit     eRst;

    function automatic longint maxOf(input int k);
        return (longint'(1) << cw[k]) - 1;
    endfunction

    function automatic longint val(input int k, input longint n);
        if (n <= maxOf(k)) return n;
        return (sat[k] != 0) ? maxOf(k) : (n % (maxOf(k) + 1));
    endfunction

    function automatic logic [7:0] expOvf(input int k);
        logic [7:0] b;
        for (int i = 0; i < NE; i++) b[i] = (mCnt[k][i] > maxOf(k));
        return b;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input int idx);
        rd_req = 1'b1;
        rd_idx = 4'(idx);
        tick();
        rd_req = 1'b0;
        tick();
    endtask

    task automatic model_edge();
        eRst = !rst_n;
        for (int k = 0; k < NK; k++) begin
            if (!rst_n || clr) begin
                eAck[k]  = 1'b0;
                mPend[k] = 1'b0;
                mSt[k]   = 0;
                for (int i = 0; i <= NE; i++) mCnt[k][i] = 0;
            end else begin
                eAck[k] = mPend[k];
                if (mPend[k]) begin
                    eErr[k]  = (mIdx[k] > NE);
                    eData[k] = eErr[k] ? 0 : val(k, mCnt[k][mIdx[k]]);
                end
                mPend[k] = rd_req && !mPend[k];
                if (mPend[k]) mIdx[k] = int'(rd_idx);
                if (mSt[k] == 0) begin
                    if (en) mSt[k] = 1;
                end else if (mSt[k] == 1) begin
                    mCnt[k][NE]++;
                    for (int i = 0; i < NE; i++)
                        if (evt[i]) mCnt[k][i]++;
                    if (hlt) mSt[k] = 2;
                    else if (maxc[k] != 0 && val(k, mCnt[k][NE]) == maxc[k])
                        mSt[k] = 3;
                end
            end
        end
    endtask

    task automatic rand_cycle(input bit r, input bit c, input bit e,
                              input bit h, input logic [7:0] ev,
                              input bit rq, input int ri);
        rst_n  = r;
        clr    = c;
        en     = e;
        hlt    = h;
        evt    = ev;
        rd_req = rq;
        rd_idx = 4'(ri);
        @(posedge clk);
        model_edge();
        #1;
        for (int k = 0; k < NK; k++) begin
            nChk++;
            if (oSt[k] !== 2'(mSt[k])) begin
                nFail++;
                $display("FAIL rnd_state k=%0d got %0d want %0d", k, oSt[k], mSt[k]);
            end
            nChk++;
            if (oDone[k] !== (mSt[k] >= 2)) begin
                nFail++;
                $display("FAIL rnd_done k=%0d got %0d want %0d", k, oDone[k], mSt[k] >= 2);
            end
            nChk++;
            if (oOvf[k] !== expOvf(k)) begin
                nFail++;
                $display("FAIL rnd_ovf k=%0d got %h want %h", k, oOvf[k], expOvf(k));
            end
            nChk++;
            if (oAck[k] !== eAck[k]) begin
                nFail++;
                $display("FAIL rnd_ack k=%0d got %0d want %0d", k, oAck[k], eAck[k]);
            end
            if (eAck[k]) begin
                nChk++;
                if (oData[k] !== 32'(eData[k]) || oErr[k] !== eErr[k]) begin
                    nFail++;
                    $display("FAIL rnd_data k=%0d idx=%0d got %0d/%0d want %0d/%0d",
                             k, mIdx[k], oData[k], oErr[k], eData[k], eErr[k]);
                end
            end
            if (eRst) begin
                nChk++;
                if (oData[k] !== 32'd0 || oErr[k] !== 1'b0) begin
                    nFail++;
                    $display("FAIL rnd_rst_rd k=%0d got %0d/%0d want 0/0", k, oData[k], oErr[k]);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; hlt = 1'b0; clr = 1'b0;
        rd_req = 1'b0; rd_idx = '0; evt = '0;
        tick();
        tick();
        for (int k = 0; k < NK; k++) begin
            nChk++;
            if (oSt[k] !== 2'd0 || oDone[k] !== 1'b0) begin
                nFail++;
                $display("FAIL reset_state k=%0d got %0d/%0d want 0/0", k, oSt[k], oDone[k]);
            end
            nChk++;
            if (oAck[k] !== 1'b0 || oData[k] !== 32'd0 || oErr[k] !== 1'b0) begin
                nFail++;
                $display("FAIL reset_rd k=%0d got %0d/%0d/%0d want 0/0/0",
                         k, oAck[k], oData[k], oErr[k]);
            end
            nChk++;
            if (oOvf[k] !== 8'd0) begin
                nFail++;
                $display("FAIL reset_ovf k=%0d got %h want 00", k, oOvf[k]);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_halt();
        tick();
        tick();
        en = 1'b1;
        tick();
        en = 1'b0;
        evt = 8'h01;
        for (int c = 1; c <= 10; c++) begin
            hlt = (c == 10);
            tick();
        end
        evt = '0;
        hlt = 1'b0;
        for (int k = 0; k < NK; k++) begin
            nChk++;
            if (oSt[k] !== 2'd2 || oDone[k] !== 1'b1) begin
                nFail++;
                $display("FAIL halt_state k=%0d got %0d/%0d want 2/1", k, oSt[k], oDone[k]);
            end
        end
        do_read(0);
        for (int k = 0; k < NK; k++) begin
            nChk++;
            if (oAck[k] !== 1'b1 || oData[k] !== 32'd10) begin
                nFail++;
                $display("FAIL halt_ch0 k=%0d got %0d/%0d want 1/10", k, oAck[k], oData[k]);
            end
        end
        do_read(NE);
        for (int k = 0; k < NK; k++) begin
            nChk++;
            if (oData[k] !== 32'd10) begin
                nFail++;
                $display("FAIL halt_cyc k=%0d got %0d want 10", k, oData[k]);
            end
        end
    endtask

    task automatic test_overflow();
        int        expCh [NK];
        int        expSt [NK];
        logic [7:0] expOv [NK];
        expCh = '{300, 50, 255, 44};
        expSt = '{2, 3, 2, 2};
        expOv = '{8'h00, 8'h00, 8'h02, 8'h02};
        clr = 1'b1;
        tick();
        clr = 1'b0;
        en = 1'b1;
        tick();
        en = 1'b0;
        evt = 8'h02;
        for (int c = 1; c <= 300; c++) begin
            hlt = (c == 300);
            tick();
        end
        evt = '0;
        hlt = 1'b0;
        do_read(1);
        for (int k = 0; k < NK; k++) begin
            nChk++;
            if (oData[k] !== 32'(expCh[k])) begin
                nFail++;
                $display("FAIL ovf_ch1 k=%0d got %0d want %0d", k, oData[k], expCh[k]);
            end
            nChk++;
            if (oOvf[k] !== expOv[k]) begin
                nFail++;
                $display("FAIL ovf_flag k=%0d got %h want %h", k, oOvf[k], expOv[k]);
            end
            nChk++;
            if (oSt[k] !== 2'(expSt[k])) begin
                nFail++;
                $display("FAIL ovf_state k=%0d got %0d want %0d", k, oSt[k], expSt[k]);
            end
        end
        do_read(NE);
        for (int k = 0; k < NK; k++) begin
            nChk++;
            if (oData[k] !== 32'(expCh[k])) begin
                nFail++;
                $display("FAIL ovf_cyc k=%0d got %0d want %0d", k, oData[k], expCh[k]);
            end
        end
    endtask

    task automatic test_watchdog();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        en = 1'b1;
        tick();
        en = 1'b0;
        evt = 8'h01;
        for (int c = 1; c <= 49; c++) tick();
        nChk++;
        if (oSt[1] !== 2'd1) begin
            nFail++;
            $display("FAIL wd_early got %0d want 1", oSt[1]);
        end
        tick();
        nChk++;
        if (oSt[1] !== 2'd3 || oDone[1] !== 1'b1) begin
            nFail++;
            $display("FAIL wd_timeout got %0d/%0d want 3/1", oSt[1], oDone[1]);
        end
        for (int c = 0; c < 5; c++) tick();
        evt = '0;
        do_read(0);
        nChk++;
        if (oData[1] !== 32'd50) begin
            nFail++;
            $display("FAIL wd_frozen_ch0 got %0d want 50", oData[1]);
        end
        do_read(NE);
        nChk++;
        if (oData[1] !== 32'd50) begin
            nFail++;
            $display("FAIL wd_frozen_cyc got %0d want 50", oData[1]);
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        en = 1'b1;
        tick();
        en = 1'b0;
        for (int c = 1; c <= 50; c++) begin
            hlt = (c == 50);
            tick();
        end
        hlt = 1'b0;
        nChk++;
        if (oSt[1] !== 2'd2 || oSt[0] !== 2'd2) begin
            nFail++;
            $display("FAIL wd_hlt_wins got %0d/%0d want 2/2", oSt[1], oSt[0]);
        end
    endtask

    task automatic test_read_handshake();
        int acks;
        rd_req = 1'b1;
        rd_idx = 4'(NE);
        tick();
        rd_req = 1'b0;
        nChk++;
        if (oAck[0] !== 1'b0) begin
            nFail++;
            $display("FAIL rd_early_ack got %0d want 0", oAck[0]);
        end
        tick();
        nChk++;
        if (oAck[0] !== 1'b1 || oData[0] !== 32'd50 || oErr[0] !== 1'b0) begin
            nFail++;
            $display("FAIL rd_ack_data got %0d/%0d/%0d want 1/50/0",
                     oAck[0], oData[0], oErr[0]);
        end
        tick();
        nChk++;
        if (oAck[0] !== 1'b0) begin
            nFail++;
            $display("FAIL rd_ack_width got %0d want 0", oAck[0]);
        end
        acks = 0;
        rd_req = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            acks += int'(oAck[0]);
        end
        rd_req = 1'b0;
        tick();
        acks += int'(oAck[0]);
        nChk++;
        if (acks != 2) begin
            nFail++;
            $display("FAIL rd_held_acks got %0d want 2", acks);
        end
        do_read(NE + 1);
        for (int k = 0; k < NK; k++) begin
            nChk++;
            if (oAck[k] !== 1'b1 || oErr[k] !== 1'b1 || oData[k] !== 32'd0) begin
                nFail++;
                $display("FAIL rd_err k=%0d got %0d/%0d/%0d want 1/1/0",
                         k, oAck[k], oErr[k], oData[k]);
            end
        end
    endtask

    task automatic test_clr();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        en = 1'b1;
        tick();
        en = 1'b0;
        evt = 8'h01;
        for (int c = 0; c < 5; c++) tick();
        rd_req = 1'b1;
        rd_idx = 4'd0;
        tick();
        rd_req = 1'b0;
        clr = 1'b1;
        evt = 8'hFF;
        tick();
        clr = 1'b0;
        evt = '0;
        for (int k = 0; k < NK; k++) begin
            nChk++;
            if (oAck[k] !== 1'b0 || oSt[k] !== 2'd0) begin
                nFail++;
                $display("FAIL clr_ack_state k=%0d got %0d/%0d want 0/0", k, oAck[k], oSt[k]);
            end
        end
        tick();
        nChk++;
        if (oAck[0] !== 1'b0) begin
            nFail++;
            $display("FAIL clr_stale_ack got %0d want 0", oAck[0]);
        end
        do_read(0);
        nChk++;
        if (oData[0] !== 32'd0 || oOvf[0] !== 8'd0) begin
            nFail++;
            $display("FAIL clr_counts got %0d/%h want 0/00", oData[0], oOvf[0]);
        end
        en = 1'b1;
        evt = 8'h01;
        tick();
        en = 1'b0;
        for (int c = 0; c < 3; c++) tick();
        evt = '0;
        do_read(0);
        for (int k = 0; k < NK; k++) begin
            nChk++;
            if (oData[k] !== 32'd3 || oSt[k] !== 2'd1) begin
                nFail++;
                $display("FAIL clr_rearm k=%0d got %0d/%0d want 3/1", k, oData[k], oSt[k]);
            end
        end
    endtask

    task automatic test_random();
        rand_cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 0);
        for (int i = 0; i < 10000; i++) begin
            rand_cycle(i != 5000,
                       $urandom_range(0, 299) == 0,
                       $urandom_range(0, 3) == 0,
                       $urandom_range(0, 599) == 0,
                       8'($urandom),
                       $urandom_range(0, 2) == 0,
                       int'($urandom_range(0, 10)));
        end
        for (int idx = 0; idx <= NE; idx++) begin
            rand_cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, idx);
            rand_cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0, 0);
        end
    endtask

    initial begin
        test_reset();
        test_halt();
        test_overflow();
        test_watchdog();
        test_read_handshake();
        test_clr();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", nChk, nFail);
        $finish;
    end

endmodule
